// File: rtl/way_replace_ctrl.sv
// True-LRU way replacement for an 8-way cache: resolves hit way or miss victim onto way_out.
// Response 2 cycles after acceptance; req_ready is low while busy and while flush is sampled.
module way_replace_ctrl #(
  parameter int SET_BITS = 2,
  parameter int WAYS     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic                req_hit,
  input  logic [2:0]          req_hit_way,
  input  logic                flush,
  output logic                rsp_valid,
  output logic [2:0]          way_out,
  output logic                rsp_was_evict
);

  localparam int NUM_SETS = 2**SET_BITS;

  typedef enum logic [1:0] {IDLE, SELECT, UPDATE} state_t;

  state_t              state, state_nxt;
  logic [WAYS-1:0]     valid [NUM_SETS];
  logic [2:0]          age   [NUM_SETS][WAYS];

  logic [SET_BITS-1:0] lat_set;
  logic                lat_hit;
  logic [2:0]          lat_way;
  logic [2:0]          sel_q;
  logic                evict_q;

  logic                accept;
  logic                do_flush;
  logic [2:0]          pick_way;
  logic                pick_evict;
  logic                found;
  logic [2:0]          sel_age;
  logic [2:0]          new_age [WAYS];

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    do_flush  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !flush;
        do_flush  = flush;
        accept    = req_valid && !flush;
        if (accept) state_nxt = SELECT;
      end
      SELECT:  state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Miss: lowest invalid way wins; only a full set falls back to the LRU way.
  always_comb begin
    pick_way   = 3'd0;
    pick_evict = 1'b0;
    found      = 1'b0;
    if (lat_hit) begin
      pick_way = lat_way;
    end else begin
      for (int w = WAYS-1; w >= 0; w--) begin
        if (!valid[lat_set][w]) begin
          pick_way = 3'(w);
          found    = 1'b1;
        end
      end
      if (!found) begin
        pick_evict = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (age[lat_set][w] == 3'd7) pick_way = 3'(w);
        end
      end
    end
  end

  // Ways younger than the selected one age by one; the selected way becomes MRU.
  always_comb begin
    sel_age = age[lat_set][sel_q];
    for (int w = 0; w < WAYS; w++) begin
      if (3'(w) == sel_q)
        new_age[w] = 3'd0;
      else if (age[lat_set][w] < sel_age)
        new_age[w] = age[lat_set][w] + 3'd1;
      else
        new_age[w] = age[lat_set][w];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      lat_set       <= '0;
      lat_hit       <= 1'b0;
      lat_way       <= 3'd0;
      sel_q         <= 3'd0;
      evict_q       <= 1'b0;
      rsp_valid     <= 1'b0;
      way_out       <= 3'd0;
      rsp_was_evict <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) age[s][w] <= 3'(w);
      end
    end else begin
      state     <= state_nxt;
      rsp_valid <= 1'b0;
      if (do_flush) begin
        for (int s = 0; s < NUM_SETS; s++) valid[s] <= '0;
      end
      if (accept) begin
        lat_set <= req_set;
        lat_hit <= req_hit;
        lat_way <= req_hit_way;
      end
      if (state == SELECT) begin
        sel_q   <= pick_way;
        evict_q <= pick_evict;
      end
      if (state == UPDATE) begin
        for (int w = 0; w < WAYS; w++) age[lat_set][w] <= new_age[w];
        if (!lat_hit) valid[lat_set][sel_q] <= 1'b1;
        rsp_valid     <= 1'b1;
        way_out       <= sel_q;
        rsp_was_evict <= evict_q;
      end
    end
  end

endmodule

// File: tb/tb_way_replace_ctrl.sv
// Randomized scoreboard bench for way_replace_ctrl against a recency-list LRU model.
module tb_way_replace_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_set = 2'd0;
  logic       req_hit = 1'b0;
  logic [2:0] req_hit_way = 3'd0;
  logic       flush = 1'b0;
  logic       rsp_valid;
  logic [2:0] way_out;
  logic       rsp_was_evict;

  way_replace_ctrl #(.SET_BITS(2), .WAYS(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_hit(req_hit), .req_hit_way(req_hit_way), .flush(flush),
    .rsp_valid(rsp_valid), .way_out(way_out), .rsp_was_evict(rsp_was_evict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int pass  = 0;

  typedef struct {
    int way;
    int ev;
    int acc;
  } exp_t;
  exp_t sb[$];

  // Model: valid flags plus a recency list per set (position 0 = most recent).
  bit mvalid [4][8];
  int lru    [4][8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 8; i++) begin
        mvalid[s][i] = 1'b0;
        lru[s][i]    = i;
      end
  endfunction

  function automatic void model_access(input int s, input bit h, input int w, input int acc);
    int sel;
    int pos;
    int ev;
    exp_t e;
    ev = 0;
    pos = 0;
    if (h) sel = w;
    else begin
      sel = -1;
      for (int i = 0; i < 8; i++)
        if (!mvalid[s][i] && sel < 0) sel = i;
      if (sel < 0) begin
        sel = lru[s][7];
        ev  = 1;
      end
      mvalid[s][sel] = 1'b1;
    end
    for (int i = 0; i < 8; i++)
      if (lru[s][i] == sel) pos = i;
    for (int i = pos; i > 0; i--) lru[s][i] = lru[s][i-1];
    lru[s][0] = sel;
    e.way = sel;
    e.ev  = ev;
    e.acc = acc;
    sb.push_back(e);
  endfunction

  task automatic issue(input int s, input bit h, input int w, input bit hold, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    req_valid   = 1'b1;
    req_set     = 2'(s);
    req_hit     = h;
    req_hit_way = 3'(w);
    forever begin
      #1;
      if (req_ready) break;
      n++;
      if (n > 10) begin
        total++;
        $display("FAIL accept_timeout: got no acceptance expected one within 10 cycles");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    acc = cyc + 1;
    model_access(s, h, w, acc);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL %s: got %0d pending responses expected 0", name, sb.size());
    end
  endtask

  task automatic do_flush(input bit with_req);
    wait_drain("flush_drain");
    @(negedge clk);
    flush     = 1'b1;
    req_valid = with_req;
    req_set   = 2'd1;
    req_hit   = 1'b0;
    #1;
    check("flush_blocks_ready", int'(req_ready), 0);
    @(posedge clk);
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 8; i++) mvalid[s][i] = 1'b0;
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 way=%0d expected no response", way_out);
        end else begin
          e = sb.pop_front();
          check("rsp_way", int'(way_out), e.way);
          check("rsp_evict", int'(rsp_was_evict), e.ev);
          check("rsp_latency", cyc, e.acc + 2);
        end
      end
    end
  end

  initial begin
    int acc;
    int prev;
    int s;
    int r;
    model_reset();
    #2;
    check("reset_ready", int'(req_ready), 1);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_way_out", int'(way_out), 0);
    check("reset_evict", int'(rsp_was_evict), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) issue(0, 1'b0, 0, 1'b0, acc);
    issue(0, 1'b0, 0, 1'b0, acc);
    issue(0, 1'b1, 3, 1'b0, acc);
    issue(0, 1'b0, 0, 1'b0, acc);
    issue(2, 1'b1, 5, 1'b0, acc);
    wait_drain("directed_drain");

    // Back-to-back with req_valid held high.
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      issue(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1, acc);
      if (prev >= 0) check("hold_spacing", acc - prev, 3);
      prev = acc;
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain("hold_drain");

    for (int i = 0; i < 8; i++) issue(1, 1'b0, 0, 1'b0, acc);
    do_flush(1'b1);
    issue(1, 1'b0, 0, 1'b0, acc);
    wait_drain("flush_resp_drain");

    // Reset while the request sits in SELECT.
    issue(3, 1'b0, 0, 1'b0, acc);
    reset = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check("midreset_ready", int'(req_ready), 1);
    check("midreset_rsp_valid", int'(rsp_valid), 0);
    check("midreset_way_out", int'(way_out), 0);
    check("midreset_evict", int'(rsp_was_evict), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    issue(0, 1'b0, 0, 1'b0, acc);
    wait_drain("post_reset_drain");

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      s = int'($urandom_range(0, 3));
      if (r < 6) do_flush(1'($urandom_range(0, 1)));
      else issue(s, 1'(r < 45), int'($urandom_range(0, 7)), 1'b0, acc);
    end
    wait_drain("final_drain");
    check("final_queue_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/way_replace_ctrl.md
Name: way_replace_ctrl

Overview:
- Replacement-policy stage for the 8-way set-associative cache, one level upstream of the 3-to-8 way-select decoder.
- Per set, tracks valid bits and true-LRU age per way; on each access it resolves a 3-bit way index (hit way, or victim on miss) and presents it on way_out.
- way_out drives the decoder input directly; the decoder's one-hot output gates the per-way data/tag write enables.

Parameters:
- SET_BITS, 2, set index width; NUM_SETS = 2**SET_BITS
- WAYS, 8, fixed; way index is 3 bits. Any other value is unsupported.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  access request
- req_ready  output  1  block can accept a request this cycle
- req_set  input  SET_BITS  set index of the access
- req_hit  input  1  1 = tag hit, 0 = miss/allocate
- req_hit_way  input  3  hit way; used only when req_hit=1
- flush  input  1  invalidate all ways of all sets
- rsp_valid  output  1  way_out is valid; 1-cycle pulse
- way_out  output  3  resolved way index, fed to the decoder
- rsp_was_evict  output  1  miss replaced a valid line

Behaviour:
- Reset (reset=0, async): state=IDLE; req_ready=1; rsp_valid=0; way_out=0; rsp_was_evict=0; all valid bits=0; age[s][w]=w for every set (way 7 is LRU).
- Ages in each set are always a permutation of 0..7 (0 = MRU, 7 = LRU).
- Request is accepted on a clock edge where req_valid=1, req_ready=1 and flush=0. The block latches set, hit and hit_way.
- FSM states: IDLE -> SELECT -> UPDATE -> IDLE. req_ready=1 only in IDLE.
- SELECT, hit path: sel = latched hit_way.
- SELECT, miss path:
  - sel = lowest-numbered way with valid=0.
  - If all 8 ways are valid, sel = the way with age==7.
  - evict = 1 only when all ways are valid.
- UPDATE:
  - Let a = old age[set][sel].
  - Every way w in the set with age < a increments by 1; age[set][sel] becomes 0; all other ways keep their age.
  - On a miss, valid[set][sel] is set to 1.
  - In the same cycle: rsp_valid=1, way_out=sel, rsp_was_evict=evict.
- Latency: request accepted at edge T; rsp_valid is high during the cycle after edge T+2; req_ready returns high in that same cycle, so back-to-back throughput is 1 access per 3 cycles.
- way_out and rsp_was_evict hold their value until the next response. rsp_valid is low outside UPDATE.
- Hit on an invalid way: ages update as normal; the valid bit stays unchanged. The block does not flag an error.
- flush:
  - Sampled only in IDLE.
  - Takes priority over a simultaneous req_valid; the request is not accepted (req_ready drops to 0 that cycle).
  - Clears every valid bit in one cycle; ages are untouched.
  - flush asserted outside IDLE is ignored; the requester holds it until req_ready=1.
- Reset asserted mid-operation: immediate return to the reset state. The pending response is dropped and no partial age or valid update remains.
- Age arithmetic is 3-bit unsigned. Increment never wraps because only ages below a (a≤7) increment.

Test Plan:
- Reset, then 8 misses to set 0 -> way_out = 0,1,…,7 in order, rsp_was_evict=0 each time; afterwards ages: way7=0, way0=7.
- Continue: 9th miss to set 0 -> way_out=0, rsp_was_evict=1. Then a hit on way 3 followed by a miss -> way_out=1 (LRU).
- Hit way 5 in set 2 after reset (ages = w) -> way5 age 0, ways 0–4 ages 1–5, ways 6,7 unchanged at 6,7; rsp_valid exactly 2 cycles after acceptance.
- req_valid held high continuously -> acceptances spaced 3 cycles apart; req_ready=0 in SELECT/UPDATE; no request lost or duplicated.
- Fill set 1 completely, then flush and req_valid together in IDLE -> request not accepted that cycle; the next miss to set 1 returns way_out=0 with rsp_was_evict=0.
- Assert reset during SELECT -> rsp_valid never pulses; all outputs and state read back as reset values; the next miss returns way_out=0.
